mem_responder: RTL

Memory-side responder for the fetch/decode/execute control unit. Serves instruction fetches on the `f` strobe and load/store requests on the `cs`/`rw` strobes. Holds a program counter, an instruction register that drives `ins_code` back to the control unit, and a parameterised data array with configurable access latency. It sits between the control unit and the ALU datapath, completing the memory interface the control unit initiates.

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 92 +++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: bus between the control unit and the memory responder.
// The err signal exists only when MEMRSP_ERR_EN is defined.
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic f;
    logic cs;
    logic rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] instr;
    logic [1:0] ins_code;
    logic [ADDR_W-1:0] pc;
    logic busy;
    logic ack;
`ifdef MEMRSP_ERR_EN
    logic err;
`endif
    modport master (
        output f, cs, rw, addr, wdata,
        input rdata, instr, ins_code, pc, busy, ack
`ifdef MEMRSP_ERR_EN
        , err
`endif
    );
    modport slave (
        input f, cs, rw, addr, wdata,
        output rdata, instr, ins_code, pc, busy, ack
`ifdef MEMRSP_ERR_EN
        , err
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: instruction fetch, program counter and wait-stated load/store responder.
// Defining MEMRSP_ERR_EN adds a sticky err output for ignored requests and out-of-range accesses.
module mem_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH = 16,
    parameter int WAIT_CYCLES = 1
) (
    input logic clk,
    input logic rst_n,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic cs_q, f_q, req, fetch, commit, in_range;
    logic rw_cap, op_rw;
    logic [ADDR_W-1:0] addr_cap, op_addr, pc;
    logic [DATA_W-1:0] wdata_cap, op_wdata, rdata, instr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req = bus.cs && !cs_q;
    assign fetch = bus.f && !f_q;
    // with zero wait states the access commits straight out of IDLE from the live request
    assign op_addr = (state == IDLE) ? bus.addr : addr_cap;
    assign op_rw = (state == IDLE) ? bus.rw : rw_cap;
    assign op_wdata = (state == IDLE) ? bus.wdata : wdata_cap;
    assign in_range = {1'b0, op_addr} < (ADDR_W+1)'(DEPTH);
    assign commit = (state_nx == RESP) && (state != RESP);

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: if (req) begin
                state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_nx = 3'(WAIT_CYCLES - 1);
            end
            WAIT: begin
                state_nx = (cnt == 3'd0) ? RESP : WAIT;
                cnt_nx = cnt - 3'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            cs_q <= 1'b0;
            f_q <= 1'b0;
            rdata <= '0;
            instr <= '0;
            pc <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            cs_q <= bus.cs;
            f_q <= bus.f;
            if (fetch) begin
                instr <= mem[pc];
                pc <= (pc == ADDR_W'(DEPTH - 1)) ? '0 : pc + ADDR_W'(1);
            end
            if (commit && op_rw) rdata <= in_range ? mem[op_addr] : '0;
        end
    end

    // a fetch of the word being stored reads the old value through the non-blocking update
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_cap <= bus.addr;
            rw_cap <= bus.rw;
            wdata_cap <= bus.wdata;
        end
        if (rst_n && commit && !op_rw && in_range) mem[op_addr] <= op_wdata;
    end

`ifdef MEMRSP_ERR_EN
    logic err;
    always_ff @(posedge clk)
        err <= !rst_n ? 1'b0 : err | (req && state != IDLE) | (commit && !in_range);
    assign bus.err = err;
`endif

    assign bus.rdata = rdata;
    assign bus.instr = instr;
    assign bus.ins_code = instr[DATA_W-1 -: 2];
    assign bus.pc = pc;
    assign bus.busy = state != IDLE;
    assign bus.ack = state == RESP;
endmodule
